// File: rtl/dai_stereo_fifo.sv
// Elastic stereo buffer: splits the receiver's interleaved L/R stream into two FIFOs,
// prefills after lock and serves mixer pops with a fixed one-cycle ack, inserting silence on underrun.
`timescale 1ns/1ps
module dai_stereo_fifo #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 24,
    parameter int PREFILL    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  ack_i,
    input  logic                  lrck_i,
    input  logic                  locked_i,
    input  logic [1:0]            pop_i,
    output logic [1:0]            ack_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  running_o,
    output logic [DEPTH_LOG2:0]   level_l_o,
    output logic [DEPTH_LOG2:0]   level_r_o,
    output logic [7:0]            underrun_cnt_o,
    output logic [7:0]            overrun_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL    = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PREFILL_LEVEL = (DEPTH_LOG2+1)'(PREFILL);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]    mem_l [DEPTH];
    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_l, rd_ptr_l, wr_ptr_r, rd_ptr_r;

    logic             pop_l, pop_r;
    logic             empty_l, empty_r, full_l, full_r;
    logic             wr_en, wr_l, wr_r, drop;
    logic             rd_l, rd_r, underrun;
    logic [WIDTH-1:0] data_nxt;

    assign level_l_o = wr_ptr_l - rd_ptr_l;
    assign level_r_o = wr_ptr_r - rd_ptr_r;
    assign running_o = (state == RUN);

    // Full/empty are taken from the registered levels, so a same-cycle pop never frees room
    // for a write and a same-cycle write never rescues a pop (read-first).
    always_comb begin
        pop_l    = pop_i[0];
        pop_r    = pop_i[1] & ~pop_i[0];
        empty_l  = (level_l_o == '0);
        empty_r  = (level_r_o == '0);
        full_l   = (level_l_o == FULL_LEVEL);
        full_r   = (level_r_o == FULL_LEVEL);
        wr_en    = ack_i && (state != IDLE) && locked_i;
        wr_l     = wr_en && lrck_i && !full_l;
        wr_r     = wr_en && !lrck_i && !full_r;
        drop     = wr_en && (lrck_i ? full_l : full_r);
        rd_l     = (state == RUN) && pop_l && !empty_l;
        rd_r     = (state == RUN) && pop_r && !empty_r;
        underrun = (state == RUN) && ((pop_l && empty_l) || (pop_r && empty_r));
        data_nxt = '0;
        if (rd_l) begin
            data_nxt = mem_l[rd_ptr_l[DEPTH_LOG2-1:0]];
        end else if (rd_r) begin
            data_nxt = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
        end
    end

    always_comb begin
        state_nxt = state;
        if (!locked_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = FILL;
                FILL:    if (level_l_o >= PREFILL_LEVEL && level_r_o >= PREFILL_LEVEL) state_nxt = RUN;
                RUN:     if (underrun) state_nxt = FILL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            ack_o          <= '0;
            data_o         <= '0;
            wr_ptr_l       <= '0;
            rd_ptr_l       <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            underrun_cnt_o <= '0;
            overrun_cnt_o  <= '0;
        end else begin
            state  <= state_nxt;
            ack_o  <= {pop_r, pop_l};
            data_o <= data_nxt;
            if (!locked_i) begin
                wr_ptr_l <= '0;
                rd_ptr_l <= '0;
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (wr_l) wr_ptr_l <= wr_ptr_l + 1'b1;
                if (wr_r) wr_ptr_r <= wr_ptr_r + 1'b1;
                if (rd_l) rd_ptr_l <= rd_ptr_l + 1'b1;
                if (rd_r) rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            if (underrun && underrun_cnt_o != 8'hFF) underrun_cnt_o <= underrun_cnt_o + 8'd1;
            if (drop && overrun_cnt_o != 8'hFF)      overrun_cnt_o  <= overrun_cnt_o + 8'd1;
        end
    end

    // Sample storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst && wr_l) mem_l[wr_ptr_l[DEPTH_LOG2-1:0]] <= data_i;
        if (rst && wr_r) mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= data_i;
    end

endmodule
